i_fetcher: RTL and testbench

//  Instruction-fetch stage of the V850-class core. Holds the program counter and

---
 rtl/i_fetcher.sv | 95 +++++++++
 tb/tb_i_fetcher.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i_fetcher.sv
// i_fetcher: instruction-fetch stage.
// Holds the fetch PC and drives a halfword-addressed instruction memory with
// a combinational read. Each rising edge it registers the 16/32-bit
// instruction found at PC, together with that PC, for the decode stage. It
// then advances PC by the instruction length. The decode stage can stall the
// fetch, and a branch/jump redirect squashes the current fetch.
//
// Ports
//   clk, rst_n     clock; asynchronous active-low reset
//   PC_o           current fetch PC (byte address, bit0 always 0)
//   imem_addr_o    halfword address to memory, combinational from PC_o
//   imem_rdata_i   {halfword at PC+2, halfword at PC}
//   imem_ready_i   read data valid this cycle (0 = memory wait)
//   stall_i        decode not accepting; hold PC and instruction outputs
//   redirect_i     taken branch/jump; load redirect_pc_i, squash output
//   redirect_pc_i  redirect target byte address (bit0 ignored)
//   instr_o        fetched instruction (upper half 0 when 16-bit)
//   instr_pc_o     PC of instr_o
//   instr_len32_o  1 = instr_o is a 32-bit instruction
//   instr_valid_o  instr_o / instr_pc_o valid
module i_fetcher #(
  parameter int unsigned     PC_W     = 25,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [PC_W-1:0] PC_o,
  output logic [PC_W-2:0] imem_addr_o,
  input  logic [31:0]     imem_rdata_i,
  input  logic            imem_ready_i,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [PC_W-1:0] redirect_pc_i,
  output logic [31:0]     instr_o,
  output logic [PC_W-1:0] instr_pc_o,
  output logic            instr_len32_o,
  output logic            instr_valid_o
);

  localparam int unsigned HW_W = 16;

  // Handshake inputs that are X/Z act as idle: no stall, no redirect, and
  // memory ready. This lets the unit free-run when left unconnected.
  logic stall;
  logic redirect;
  logic ready;

  assign stall    = (stall_i === 1'b1);
  assign redirect = (redirect_i === 1'b1);
  assign ready    = (imem_ready_i !== 1'b0);

  // The memory sees the halfword index of the fetch PC.
  assign imem_addr_o = PC_o[PC_W-1:1];

  // Length decode. Opcode bits [10:9] == 2'b11 mark a 32-bit instruction.
  logic [HW_W-1:0] hw0;
  logic            is32;
  logic [31:0]     instr_dec;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] redirect_pc;

  always_comb begin
    hw0         = imem_rdata_i[HW_W-1:0];
    is32        = (hw0[10:9] == 2'b11);
    instr_dec   = is32 ? imem_rdata_i : {16'h0000, hw0};
    pc_inc      = PC_o + (is32 ? PC_W'(4) : PC_W'(2));
    redirect_pc = redirect_pc_i & ~PC_W'(1);
  end

  // Fetch register. The priority order is redirect, then stall, then memory
  // wait, then a normal fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC_o          <= RESET_PC;
      instr_o       <= '0;
      instr_pc_o    <= '0;
      instr_len32_o <= 1'b0;
      instr_valid_o <= 1'b0;
    end else if (redirect) begin
      PC_o          <= redirect_pc;
      instr_valid_o <= 1'b0;
    end else if (stall) begin
      PC_o          <= PC_o;
    end else if (!ready) begin
      instr_valid_o <= 1'b0;
    end else begin
      instr_o       <= instr_dec;
      instr_pc_o    <= PC_o;
      instr_len32_o <= is32;
      instr_valid_o <= 1'b1;
      PC_o          <= pc_inc;
    end
  end

endmodule

// File: tb/tb_i_fetcher.sv
// tb_i_fetcher: randomized and directed bench for i_fetcher, using a
// halfword-array memory model and a reference model of the fetch stage.
module tb_i_fetcher;

  localparam int unsigned PC_W   = 25;
  localparam int unsigned MEM_N  = 256;
  localparam int unsigned OBS_W  = PC_W + 32 + PC_W + 2 + (PC_W - 1);
  localparam logic [PC_W-1:0] PC_MASK = '1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [PC_W-1:0] PC_o;
  logic [PC_W-2:0] imem_addr_o;
  logic [31:0]     imem_rdata_i;
  logic            imem_ready_i;
  logic            stall_i;
  logic            redirect_i;
  logic [PC_W-1:0] redirect_pc_i;
  logic [31:0]     instr_o;
  logic [PC_W-1:0] instr_pc_o;
  logic            instr_len32_o;
  logic            instr_valid_o;

  int checks   = 0;
  int failures = 0;

  logic [15:0] mem [MEM_N];

  // Reference state
  logic [PC_W-1:0] m_pc;
  logic [31:0]     m_instr;
  logic [PC_W-1:0] m_ipc;
  logic            m_len;
  logic            m_valid;

  i_fetcher #(.PC_W(PC_W), .RESET_PC('0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .PC_o          (PC_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rdata_i  (imem_rdata_i),
    .imem_ready_i  (imem_ready_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_len32_o (instr_len32_o),
    .instr_valid_o (instr_valid_o)
  );

  always #5 clk = ~clk;

  // Combinational memory: the memory wraps modulo MEM_N halfwords.
  logic [7:0] a_lo;
  logic [7:0] a_hi;
  always_comb begin
    a_lo         = imem_addr_o[7:0];
    a_hi         = a_lo + 8'd1;
    imem_rdata_i = {mem[a_hi], mem[a_lo]};
  end

  function automatic logic [15:0] hw_at(input logic [PC_W-1:0] byte_addr);
    int unsigned idx;
    idx = (int'(byte_addr) / 2) % MEM_N;
    return mem[idx];
  endfunction

  task automatic model_reset();
    m_pc = '0; m_instr = '0; m_ipc = '0; m_len = 1'b0; m_valid = 1'b0;
  endtask

  // One clock edge of the fetch stage, described at the behavioural level.
  task automatic model_step();
    logic [15:0] h0;
    logic [15:0] h1;
    logic        long_i;
    h0     = hw_at(m_pc);
    h1     = hw_at(m_pc + 2);
    long_i = (h0[10:9] == 2'b11);
    if (redirect_i) begin
      m_pc    = redirect_pc_i & ~PC_W'(1);
      m_valid = 1'b0;
    end else if (stall_i) begin
      // hold everything
    end else if (!imem_ready_i) begin
      m_valid = 1'b0;
    end else begin
      m_instr = long_i ? {h1, h0} : {16'h0000, h0};
      m_ipc   = m_pc;
      m_len   = long_i;
      m_valid = 1'b1;
      m_pc    = PC_W'((longint'(m_pc) + (long_i ? 4 : 2)) & longint'(PC_MASK));
    end
  endtask

  // Advance the model with the current inputs, then clock the DUT and settle.
  task automatic go();
    model_step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [OBS_W-1:0] obs_vec();
    return {PC_o, instr_o, instr_pc_o, instr_len32_o, instr_valid_o, imem_addr_o};
  endfunction

  function automatic logic [OBS_W-1:0] exp_vec();
    return {m_pc, m_instr, m_ipc, m_len, m_valid, m_pc[PC_W-1:1]};
  endfunction

  task automatic idle_inputs();
    stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; imem_ready_i = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < MEM_N; i++) mem[i] = 16'h0000;
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL reset_hold got=%h exp=%h", obs_vec(), exp_vec());
      end
    end
    @(negedge clk); #2 rst_n = 1'b1; #1;
    checks++;
    if (obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL reset_release got=%h exp=%h", obs_vec(), exp_vec());
    end
    for (int i = 0; i < 4; i++) begin
      go();
      checks++;
      if (obs_vec() !== exp_vec() || PC_o !== PC_W'(2 * (i + 1)) || instr_valid_o !== 1'b1) begin
        failures++;
        $display("FAIL reset_run%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic redirect_to(input logic [PC_W-1:0] pc);
    redirect_i = 1'b1; redirect_pc_i = pc;
    go();
    redirect_i = 1'b0;
  endtask

  task automatic test_len32();
    mem[0] = 16'h0660; mem[1] = 16'h1234;
    redirect_to('0);
    go();
    checks++;
    if (obs_vec() !== exp_vec() || PC_o !== PC_W'(4) || instr_o !== 32'h1234_0660 ||
        instr_len32_o !== 1'b1 || instr_pc_o !== '0) begin
      failures++;
      $display("FAIL len32 got=%h exp=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_straddle();
    mem[1] = 16'h0600; mem[2] = 16'hABCD;
    redirect_to(PC_W'(2));
    go();
    checks++;
    if (obs_vec() !== exp_vec() || PC_o !== PC_W'(6) || instr_pc_o !== PC_W'(2) ||
        instr_o !== 32'hABCD_0600) begin
      failures++;
      $display("FAIL straddle got=%h exp=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_stall();
    mem[3] = 16'h0002; mem[4] = 16'h0005; mem[5] = 16'h0000;
    redirect_to(PC_W'(6));
    go();  // fetch at 6 -> PC 8
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      go();
      checks++;
      if (obs_vec() !== exp_vec() || PC_o !== PC_W'(8) || instr_o !== 32'h0000_0002) begin
        failures++;
        $display("FAIL stall%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
    stall_i = 1'b0;
    go();
    checks++;
    if (obs_vec() !== exp_vec() || PC_o !== PC_W'(10) || instr_pc_o !== PC_W'(8)) begin
      failures++;
      $display("FAIL stall_resume got=%h exp=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_redirect();
    mem[128] = 16'h0011; mem[129] = 16'h0022;
    stall_i = 1'b1;
    redirect_to(PC_W'('h101));
    checks++;
    if (obs_vec() !== exp_vec() || PC_o !== PC_W'('h100) || instr_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL redirect_stall got=%h exp=%h", obs_vec(), exp_vec());
    end
    stall_i = 1'b0;
    imem_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      go();
      checks++;
      if (obs_vec() !== exp_vec() || PC_o !== PC_W'('h100) || instr_valid_o !== 1'b0) begin
        failures++;
        $display("FAIL mem_wait%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
    imem_ready_i = 1'b1;
    go();
    checks++;
    if (obs_vec() !== exp_vec() || PC_o !== PC_W'('h102) || instr_o !== 32'h0000_0011) begin
      failures++;
      $display("FAIL mem_resume got=%h exp=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_wrap();
    mem[255] = 16'h0003;
    redirect_to(PC_W'('h1FF_FFFE));
    go();
    checks++;
    if (obs_vec() !== exp_vec() || PC_o !== '0 || instr_pc_o !== PC_W'('h1FF_FFFE)) begin
      failures++;
      $display("FAIL wrap got=%h exp=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < MEM_N; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 400; i++) begin
      redirect_i    = ($urandom_range(0, 99) < 5);
      redirect_pc_i = PC_W'($urandom);
      stall_i       = ($urandom_range(0, 99) < 20);
      imem_ready_i  = ($urandom_range(0, 99) < 80);
      go();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL random%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    go();
    #2;  // clock still high, well before the next edge
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs_vec() !== exp_vec() || PC_o !== '0 || instr_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got=%h exp=%h", obs_vec(), exp_vec());
    end
    @(negedge clk); #2 rst_n = 1'b1;
    go();
    checks++;
    if (obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL async_release got=%h exp=%h", obs_vec(), exp_vec());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_len32();
    test_straddle();
    test_stall();
    test_redirect();
    test_wrap();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
